// File: rtl/seg_pkg.sv
// Shared types and constants for the dual 7-segment scan path.
//   scan_state_t     : scanner phase (blank/show for each of the two digits)
//   SEG_SLOT_CYCLES  : default lit time per digit, in clk cycles
//   SEG_BLANK_CYCLES : default forced-blank time before each digit, in clk cycles
//   SEG_OFF          : segment pattern with every (active-low) segment off
package seg_pkg;

  typedef enum logic [1:0] {
    StBlank0,
    StShow0,
    StBlank1,
    StShow1
  } scan_state_t;

  localparam int unsigned SEG_SLOT_CYCLES  = 6000;
  localparam int unsigned SEG_BLANK_CYCLES = 120;
  localparam logic [6:0]  SEG_OFF          = 7'b1111111;

  // True in either blanking phase.
  function automatic logic is_blank_state(input scan_state_t s);
    return (s == StBlank0) || (s == StBlank1);
  endfunction

  // True while the left digit (value[7:4]) owns the select pin.
  function automatic logic is_left_state(input scan_state_t s);
    return (s == StBlank1) || (s == StShow1);
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-phase cycle counter for the digit scanner.
//   clk   : system clock
//   rst_n : synchronous active-low reset, clears the count
//   last  : terminal count (phase length - 1) for the current phase
//   cnt   : current count, 0..last
//   done  : high on the final cycle of the phase (cnt == last); count clears next edge
module seg_slot_timer #(
  parameter int unsigned MaxCount = 1,
  parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CntW-1:0] last,
  output logic [CntW-1:0] cnt,
  output logic            done
);

  logic [CntW-1:0] cnt_q;

  // The terminal count is reloaded by the owner every phase, so the only wrap
  // is the clear on done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == last);

endmodule

// File: rtl/seg_digit_scan.sv
// Two-digit time-multiplexed scanner feeding digit_to_segments.
// Each frame is BLANK0 -> SHOW0 -> BLANK1 -> SHOW1; a new value offered over
// valid/ready is parked in a pending register and committed to the display
// shadow only at the SHOW1 -> BLANK0 boundary, so a frame never tears.
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   value_valid : upstream offers value this cycle
//   value       : [7:4] left nibble, [3:0] right nibble
//   value_ready : a value can be accepted this cycle
//   digit       : nibble currently presented to the segment decoder
//   digit_sel   : 0 = right digit, 1 = left digit (select pin)
//   blank       : 1 = segments must be forced off
//   frame_start : one-cycle pulse on the first cycle of each frame
module seg_digit_scan
  import seg_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = SEG_SLOT_CYCLES,
  parameter int unsigned BLANK_CYCLES = SEG_BLANK_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       value_valid,
  input  logic [7:0] value,
  output logic       value_ready,
  output logic [3:0] digit,
  output logic       digit_sel,
  output logic       blank,
  output logic       frame_start
);

  localparam int unsigned MaxCycles = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  scan_state_t     state_q;
  logic [7:0]      shadow_q;
  logic            pending_q;
  logic [7:0]      pending_val_q;

  logic [CntW-1:0] slot_last;
  logic [CntW-1:0] cnt;
  logic            slot_done;
  logic            xfer;
  logic            commit;

  always_comb begin
    slot_last = is_blank_state(state_q) ? CntW'(BLANK_CYCLES - 1) : CntW'(SLOT_CYCLES - 1);
  end

  seg_slot_timer #(
    .MaxCount (MaxCycles),
    .CntW     (CntW)
  ) u_slot_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .last  (slot_last),
    .cnt   (cnt),
    .done  (slot_done)
  );

  assign xfer   = value_valid && !pending_q;
  // Only a value already pending before the frame boundary commits; xfer and
  // commit are exclusive because xfer needs pending_q low.
  assign commit = (state_q == StShow1) && slot_done && pending_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StBlank0;
      shadow_q      <= 8'h00;
      pending_q     <= 1'b0;
      pending_val_q <= 8'h00;
    end else begin
      if (slot_done) begin
        unique case (state_q)
          StBlank0: state_q <= StShow0;
          StShow0:  state_q <= StBlank1;
          StBlank1: state_q <= StShow1;
          StShow1:  state_q <= StBlank0;
          default:  state_q <= StBlank0;
        endcase
      end
      if (xfer) begin
        pending_q     <= 1'b1;
        pending_val_q <= value;
      end else if (commit) begin
        shadow_q  <= pending_val_q;
        pending_q <= 1'b0;
      end
    end
  end

  // Outputs depend on registered state only.
  assign value_ready = !pending_q;
  assign digit_sel   = is_left_state(state_q);
  assign blank       = is_blank_state(state_q);
  assign digit       = digit_sel ? shadow_q[7:4] : shadow_q[3:0];
  assign frame_start = (state_q == StBlank0) && (cnt == '0);

  // A select change must always land inside a blanking interval.
  a_sel_under_blank: assert property (@(posedge clk) disable iff (!rst_n)
    (digit_sel != $past(digit_sel)) |-> blank);

  a_frame_start_blank: assert property (@(posedge clk) disable iff (!rst_n)
    frame_start |-> (blank && !digit_sel));

  a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= slot_last);

endmodule

// File: tb/tb_seg_digit_scan.sv
module tb_seg_digit_scan;

  localparam int S = 4;
  localparam int B = 2;
  localparam int F = 2 * (S + B);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       value_valid = 1'b0;
  logic [7:0] value = 8'h00;
  logic       value_ready;
  logic [3:0] digit;
  logic       digit_sel;
  logic       blank;
  logic       frame_start;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfers = 0;

  always #5 clk = ~clk;

  seg_digit_scan #(
    .SLOT_CYCLES  (S),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_valid (value_valid),
    .value       (value),
    .value_ready (value_ready),
    .digit       (digit),
    .digit_sel   (digit_sel),
    .blank       (blank),
    .frame_start (frame_start)
  );

  // Cycle index since the last reset edge.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (rst_n && value_valid && value_ready) xfers <= xfers + 1;
  end

  // Behavioural model: position within a fixed-length frame, a display value,
  // and a one-deep pending slot that swaps in at the end of a frame.
  bit         model_on = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_shadow = 8'h00;
  logic       m_pending = 1'b0;
  logic [7:0] m_pval = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_on  <= 1'b1;
      m_pos     <= 0;
      m_shadow  <= 8'h00;
      m_pending <= 1'b0;
      m_pval    <= 8'h00;
    end else if (model_on) begin
      if (value_valid && !m_pending) begin
        m_pending <= 1'b1;
        m_pval    <= value;
      end else if (m_pos == F - 1 && m_pending) begin
        m_shadow  <= m_pval;
        m_pending <= 1'b0;
      end
      m_pos <= (m_pos + 1) % F;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      logic       e_blank, e_sel, e_fs;
      logic [3:0] e_digit;
      e_blank = (m_pos < B) || (m_pos >= B + S && m_pos < 2 * B + S);
      e_sel   = (m_pos >= B + S);
      e_fs    = (m_pos == 0);
      e_digit = e_sel ? m_shadow[7:4] : m_shadow[3:0];
      check("model {ready,digit,sel,blank,fs}",
            {value_ready, digit, digit_sel, blank, frame_start},
            {!m_pending, e_digit, e_sel, e_blank, e_fs});
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    value_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc != k && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != k) begin
      checks++;
      failures++;
      $display("FAIL wait_cyc: actual=%0d required=%0d", cyc, k);
    end
  endtask

  initial begin
    int n_fs;
    int sum_fs;
    int base;

    #1;
    // Reset and free-running frame timing
    do_reset();
    n_fs = 0;
    sum_fs = 0;
    for (int c = 0; c < 40; c++) begin
      wait_cyc(c);
      if (frame_start) begin
        n_fs++;
        sum_fs += c;
      end
      if (c == 0) begin
        check("rst blank", blank, 1);
        check("rst sel", digit_sel, 0);
        check("rst digit", digit, 0);
        check("rst ready", value_ready, 1);
        check("rst frame_start", frame_start, 1);
      end
      if (c == 3) check("c3 {blank,sel}", {blank, digit_sel}, 2'b00);
      if (c == 6) check("c6 {blank,sel}", {blank, digit_sel}, 2'b11);
      if (c == 9) check("c9 {blank,sel}", {blank, digit_sel}, 2'b01);
      if (c == 13) check("c13 frame_start", frame_start, 0);
    end
    check("frame_start count", 8'(n_fs), 8'd4);
    check("frame_start cycle sum", 8'(sum_fs), 8'd72);

    // Load 8'h3A at cycle 3
    do_reset();
    wait_cyc(3);
    value = 8'h3A;
    value_valid = 1'b1;
    wait_cyc(4);
    value_valid = 1'b0;
    check("load ready c4", value_ready, 0);
    wait_cyc(9);
    check("load digit c9", digit, 4'h0);
    wait_cyc(11);
    check("load ready c11", value_ready, 0);
    wait_cyc(12);
    check("load ready c12", value_ready, 1);
    wait_cyc(15);
    check("load {digit,sel} c15", {digit, digit_sel}, {4'hA, 1'b0});
    wait_cyc(21);
    check("load {digit,sel} c21", {digit, digit_sel}, {4'h3, 1'b1});

    // Transfer on the last SHOW1 cycle
    do_reset();
    wait_cyc(11);
    value = 8'h5C;
    value_valid = 1'b1;
    wait_cyc(12);
    value_valid = 1'b0;
    check("bnd ready c12", value_ready, 0);
    wait_cyc(22);
    check("bnd digit c22", digit, 4'h0);
    wait_cyc(24);
    check("bnd ready c24", value_ready, 1);
    wait_cyc(27);
    check("bnd digit c27", digit, 4'hC);
    wait_cyc(33);
    check("bnd digit c33", digit, 4'h5);

    // Back-pressure: 8'h11 then 8'h22 held until accepted
    do_reset();
    base = xfers;
    wait_cyc(1);
    value = 8'h11;
    value_valid = 1'b1;
    wait_cyc(2);
    value = 8'h22;
    check("bp ready c2", value_ready, 0);
    wait_cyc(12);
    check("bp ready c12", value_ready, 1);
    wait_cyc(13);
    value_valid = 1'b0;
    wait_cyc(15);
    check("bp digit c15", digit, 4'h1);
    wait_cyc(21);
    check("bp digit c21", digit, 4'h1);
    wait_cyc(27);
    check("bp digit c27", digit, 4'h2);
    wait_cyc(33);
    check("bp digit c33", digit, 4'h2);
    check("bp transfer count", 8'(xfers - base), 8'd2);

    // Mid-operation reset drops a pending value
    do_reset();
    wait_cyc(3);
    value = 8'h3A;
    value_valid = 1'b1;
    wait_cyc(4);
    value_valid = 1'b0;
    wait_cyc(14);
    value = 8'h77;
    value_valid = 1'b1;
    wait_cyc(15);
    value_valid = 1'b0;
    check("mr ready c15", value_ready, 0);
    wait_cyc(21);
    check("mr digit c21", digit, 4'h3);
    do_reset();
    check("mr post {blank,digit,sel,fs,ready}",
          {blank, digit, digit_sel, frame_start, value_ready}, {1'b1, 4'h0, 1'b0, 1'b1, 1'b1});
    wait_cyc(3);
    check("mr digit c3", {blank, digit}, {1'b0, 4'h0});
    wait_cyc(15);
    check("mr digit c15", digit, 4'h0);
    wait_cyc(21);
    check("mr digit c21 after", digit, 4'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
